// File: rtl/lqq_dispatch.sv
// Round-robin dispatcher for lqq flags: presents one request with its vector
// over req/ack, tracks service until eoi, and keeps latency/withdrawal stats.
module lqq_dispatch #(
  parameter int unsigned LAT_W  = 16,
  parameter int unsigned SPUR_W = 8
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic [31:0]       gwerth,
  input  logic [255:0]      g_vector,
  input  logic [31:0]       g_lqq_enb,
  input  logic              g_lqq_ack,
  input  logic              g_lqq_eoi,
  output logic              g_lqq_req,
  output logic [4:0]        g_lqq_id,
  output logic [7:0]        g_lqq_vec,
  output logic              g_lqq_busy,
  output logic [31:0]       g_lqq_clr,
  output logic [LAT_W-1:0]  g_lqq_lat,
  output logic [SPUR_W-1:0] g_lqq_spur
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, SVC} state_t;

  state_t             state, state_nx;
  logic [31:0]        cand;
  logic [63:0]        dbl;
  logic [31:0]        rot;
  logic [4:0]         pos;
  logic [4:0]         pick;
  logic [4:0]         last_id;
  logic               withdraw;
  logic [LAT_W-1:0]   lat_cnt;

  // Rotate candidates so bit 0 is the slot after last_id; the lowest set bit
  // of the rotated word is then the round-robin winner's offset.
  always_comb begin
    cand = gwerth & g_lqq_enb;
    dbl  = {cand, cand} >> ({1'b0, last_id} + 6'd1);
    rot  = dbl[31:0];
    pos  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (rot[31 - i]) pos = 5'(31 - i);
    end
    pick     = last_id + 5'd1 + pos;
    withdraw = !(gwerth[g_lqq_id] && g_lqq_enb[g_lqq_id]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cand != '0) state_nx = ARB;
      ARB:  state_nx = (cand != '0) ? REQ : IDLE;
      REQ: begin
        if (g_lqq_ack)     state_nx = SVC;
        else if (withdraw) state_nx = IDLE;
      end
      SVC:  if (g_lqq_eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_id    <= 5'd31;
      lat_cnt    <= '0;
      g_lqq_req  <= 1'b0;
      g_lqq_busy <= 1'b0;
      g_lqq_id   <= '0;
      g_lqq_vec  <= '0;
      g_lqq_clr  <= '0;
      g_lqq_lat  <= '0;
      g_lqq_spur <= '0;
    end else begin
      state      <= state_nx;
      g_lqq_req  <= (state_nx == REQ);
      g_lqq_busy <= (state_nx == SVC);
      g_lqq_clr  <= '0;
      case (state)
        ARB: begin
          if (cand != '0) begin
            g_lqq_id  <= pick;
            g_lqq_vec <= g_vector[{pick, 3'b000} +: 8];
            lat_cnt   <= LAT_W'(1);
          end
        end
        REQ: begin
          if (g_lqq_ack) begin
            g_lqq_lat <= lat_cnt;
            g_lqq_clr <= 32'd1 << g_lqq_id;
            last_id   <= g_lqq_id;
          end else if (withdraw) begin
            if (g_lqq_spur != '1) g_lqq_spur <= g_lqq_spur + SPUR_W'(1);
          end else if (lat_cnt != '1) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lqq_dispatch.sv
// Directed plus randomized bench for lqq_dispatch, checked against a
// grant-level round-robin model kept in the bench.
module tb_lqq_dispatch;

  logic         sysclk = 1'b0;
  logic         reset_n;
  logic [31:0]  gwerth;
  logic [255:0] g_vector;
  logic [31:0]  g_lqq_enb;
  logic         g_lqq_ack;
  logic         g_lqq_eoi;
  logic         g_lqq_req;
  logic [4:0]   g_lqq_id;
  logic [7:0]   g_lqq_vec;
  logic         g_lqq_busy;
  logic [31:0]  g_lqq_clr;
  logic [3:0]   g_lqq_lat;
  logic [7:0]   g_lqq_spur;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int m_last = 31;
  int m_spur = 0;
  int m_lat  = 0;

  lqq_dispatch #(.LAT_W(4), .SPUR_W(8)) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .gwerth     (gwerth),
    .g_vector   (g_vector),
    .g_lqq_enb  (g_lqq_enb),
    .g_lqq_ack  (g_lqq_ack),
    .g_lqq_eoi  (g_lqq_eoi),
    .g_lqq_req  (g_lqq_req),
    .g_lqq_id   (g_lqq_id),
    .g_lqq_vec  (g_lqq_vec),
    .g_lqq_busy (g_lqq_busy),
    .g_lqq_clr  (g_lqq_clr),
    .g_lqq_lat  (g_lqq_lat),
    .g_lqq_spur (g_lqq_spur)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [31:0] c, input int last);
    for (int k = 1; k <= 32; k++) begin
      int idx;
      idx = (last + k) % 32;
      if (c[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic rand_vec();
    for (int i = 0; i < 8; i++) g_vector[32*i +: 32] = $urandom;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (g_lqq_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rise", 32'(g_lqq_req), 32'd1);
  endtask

  // One full grant: wait for req, ack after d REQ cycles, then eoi.
  task automatic grant(input int d);
    int         exp_id;
    logic [7:0] exp_vec;
    exp_id  = rr_pick(gwerth & g_lqq_enb, m_last);
    exp_vec = g_vector[8*exp_id +: 8];
    wait_req();
    chk("grant_id", 32'(g_lqq_id), 32'(exp_id));
    chk("grant_vec", 32'(g_lqq_vec), 32'(exp_vec));
    rand_vec();
    repeat (d - 1) tick();
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    m_lat = (d > 15) ? 15 : d;
    m_last = exp_id;
    chk("ack_req", 32'(g_lqq_req), 32'd0);
    chk("ack_busy", 32'(g_lqq_busy), 32'd1);
    chk("ack_clr", g_lqq_clr, 32'd1 << exp_id);
    chk("ack_lat", 32'(g_lqq_lat), 32'(m_lat));
    chk("vec_hold", 32'(g_lqq_vec), 32'(exp_vec));
    tick();
    chk("clr_off", g_lqq_clr, 32'd0);
    g_lqq_eoi = 1'b1;
    tick();
    g_lqq_eoi = 1'b0;
    chk("eoi_busy", 32'(g_lqq_busy), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    gwerth    = '0;
    g_vector  = '0;
    g_lqq_enb = '0;
    g_lqq_ack = 1'b0;
    g_lqq_eoi = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(g_lqq_req), 32'd0);
    chk("rst_busy", 32'(g_lqq_busy), 32'd0);
    chk("rst_clr", g_lqq_clr, 32'd0);
    chk("rst_lat", 32'(g_lqq_lat), 32'd0);
    chk("rst_spur", 32'(g_lqq_spur), 32'd0);
    chk("rst_id", 32'(g_lqq_id), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single lqq with exact timing
    gwerth = 32'h0000_0010;
    g_lqq_enb = '1;
    g_vector[8*4 +: 8] = 8'hA5;
    tick();
    chk("single_arb_noreq", 32'(g_lqq_req), 32'd0);
    tick();
    chk("single_req", 32'(g_lqq_req), 32'd1);
    chk("single_id", 32'(g_lqq_id), 32'd4);
    chk("single_vec", 32'(g_lqq_vec), 32'hA5);
    g_vector[8*4 +: 8] = 8'h11;
    tick();
    tick();
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    gwerth = '0;
    chk("single_lat", 32'(g_lqq_lat), 32'd3);
    chk("single_clr", g_lqq_clr, 32'h10);
    chk("single_busy", 32'(g_lqq_busy), 32'd1);
    chk("single_vec_hold", 32'(g_lqq_vec), 32'hA5);
    m_last = 4;
    tick();
    chk("single_clr_off", g_lqq_clr, 32'd0);
    g_lqq_eoi = 1'b1;
    tick();
    g_lqq_eoi = 1'b0;
    chk("single_eoi", 32'(g_lqq_busy), 32'd0);

    // Round-robin among 0, 1, 31
    gwerth = 32'h8000_0003;
    rand_vec();
    for (int i = 0; i < 6; i++) grant(1 + int'($urandom_range(0, 2)));

    // Masking and ignored inputs
    gwerth = '1;
    g_lqq_enb = 32'h0000_0100;
    for (int i = 0; i < 2; i++) grant(2);
    wait_req();
    chk("mask_id", 32'(g_lqq_id), 32'd8);
    g_lqq_eoi = 1'b1;
    tick();
    g_lqq_eoi = 1'b0;
    chk("eoi_in_req", 32'(g_lqq_req), 32'd1);
    chk("eoi_in_req_busy", 32'(g_lqq_busy), 32'd0);
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    chk("mask_lat", 32'(g_lqq_lat), 32'd2);
    tick();
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    chk("ack_in_svc_busy", 32'(g_lqq_busy), 32'd1);
    chk("ack_in_svc_clr", g_lqq_clr, 32'd0);
    chk("ack_in_svc_lat", 32'(g_lqq_lat), 32'd2);
    g_lqq_eoi = 1'b1;
    tick();
    g_lqq_eoi = 1'b0;
    m_last = 8;

    // Withdrawal, then ack with simultaneous drop
    gwerth = 32'h0000_0080;
    g_lqq_enb = '1;
    wait_req();
    chk("wd_id", 32'(g_lqq_id), 32'd7);
    tick();
    gwerth = '0;
    tick();
    m_spur++;
    chk("wd_req", 32'(g_lqq_req), 32'd0);
    chk("wd_spur", 32'(g_lqq_spur), 32'(m_spur));
    chk("wd_clr", g_lqq_clr, 32'd0);
    tick();
    chk("wd_idle_req", 32'(g_lqq_req), 32'd0);
    chk("wd_idle_busy", 32'(g_lqq_busy), 32'd0);
    gwerth = 32'h0000_0080;
    wait_req();
    gwerth = '0;
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    chk("ackdrop_clr", g_lqq_clr, 32'h80);
    chk("ackdrop_spur", 32'(g_lqq_spur), 32'(m_spur));
    chk("ackdrop_busy", 32'(g_lqq_busy), 32'd1);
    m_last = 7;
    g_lqq_eoi = 1'b1;
    tick();
    g_lqq_eoi = 1'b0;

    // Latency saturation
    gwerth = 32'h0000_0004;
    grant(20);

    // Spur saturation
    for (int i = 0; i < 300; i++) begin
      gwerth = 32'h0000_0004;
      wait_req();
      gwerth = '0;
      tick();
      if (m_spur < 255) m_spur++;
      if (i == 99) chk("spur_mid", 32'(g_lqq_spur), 32'(m_spur));
    end
    chk("spur_sat", 32'(g_lqq_spur), 32'd255);

    // Reset during service
    gwerth = 32'h8000_0001;
    wait_req();
    chk("pre_rst_id", 32'(g_lqq_id), 32'(rr_pick(gwerth, m_last)));
    g_lqq_ack = 1'b1;
    tick();
    g_lqq_ack = 1'b0;
    chk("pre_rst_busy", 32'(g_lqq_busy), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_req", 32'(g_lqq_req), 32'd0);
    chk("mid_rst_busy", 32'(g_lqq_busy), 32'd0);
    chk("mid_rst_clr", g_lqq_clr, 32'd0);
    chk("mid_rst_lat", 32'(g_lqq_lat), 32'd0);
    chk("mid_rst_spur", 32'(g_lqq_spur), 32'd0);
    chk("mid_rst_id", 32'(g_lqq_id), 32'd0);
    chk("mid_rst_vec", 32'(g_lqq_vec), 32'd0);
    tick();
    reset_n = 1'b1;
    m_last = 31;
    m_spur = 0;
    grant(2);
    chk("post_rst_last", 32'(m_last), 32'd0);

    // Randomized grants
    for (int i = 0; i < 10; i++) begin
      gwerth    = $urandom;
      g_lqq_enb = $urandom;
      g_lqq_enb[$urandom_range(0, 31)] = 1'b1;
      gwerth    = gwerth | (g_lqq_enb & -g_lqq_enb);
      rand_vec();
      grant(int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
